// File: rtl/yacht_turn_controller.sv
// rtl/yacht_turn_controller.sv - Yacht Dice turn sequencer: roll animation, roll limit, turn and game tracking
module yacht_turn_controller #(
  parameter int ANIM_PULSES = 8,
  parameter int ANIM_GAP    = 4,
  parameter int MAX_ROLLS   = 3,
  parameter int NUM_TURNS   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_roll,
  input  logic       btn_confirm,
  input  logic [4:0] hold_sw,
  output logic       roll_en,
  output logic [4:0] hold_mask,
  output logic [1:0] roll_count,
  output logic [3:0] turn_num,
  output logic       can_select,
  output logic       score_commit,
  output logic       game_over
);

  typedef enum logic [1:0] {WAIT_ROLL, ANIM, DECIDE, GAME_OVER} state_t;

  localparam logic [15:0] PULSES    = 16'(ANIM_PULSES);
  localparam logic [15:0] GAP_LAST  = 16'(ANIM_GAP - 1);
  localparam logic [1:0]  MAX_R     = 2'(MAX_ROLLS);
  localparam logic [3:0]  LAST_TURN = 4'(NUM_TURNS);

  state_t      state, state_n;
  logic        roll_q, conf_q;
  logic [15:0] gap_cnt, gap_cnt_n;
  logic [15:0] pulse_cnt, pulse_cnt_n;
  logic        roll_en_n, score_commit_n, can_select_n, game_over_n;
  logic [4:0]  hold_mask_n;
  logic [1:0]  roll_count_n;
  logic [3:0]  turn_num_n;
  logic        roll_edge, confirm_edge;

  assign roll_edge    = btn_roll & ~roll_q;
  assign confirm_edge = btn_confirm & ~conf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_ROLL;
      roll_q       <= 1'b1;
      conf_q       <= 1'b1;
      gap_cnt      <= '0;
      pulse_cnt    <= '0;
      roll_en      <= 1'b0;
      score_commit <= 1'b0;
      can_select   <= 1'b0;
      game_over    <= 1'b0;
      hold_mask    <= '0;
      roll_count   <= '0;
      turn_num     <= 4'd1;
    end else begin
      state        <= state_n;
      roll_q       <= btn_roll;
      conf_q       <= btn_confirm;
      gap_cnt      <= gap_cnt_n;
      pulse_cnt    <= pulse_cnt_n;
      roll_en      <= roll_en_n;
      score_commit <= score_commit_n;
      can_select   <= can_select_n;
      game_over    <= game_over_n;
      hold_mask    <= hold_mask_n;
      roll_count   <= roll_count_n;
      turn_num     <= turn_num_n;
    end
  end

  always_comb begin
    state_n        = state;
    gap_cnt_n      = gap_cnt;
    pulse_cnt_n    = pulse_cnt;
    roll_en_n      = 1'b0;
    score_commit_n = 1'b0;
    hold_mask_n    = hold_mask;
    roll_count_n   = roll_count;
    turn_num_n     = turn_num;

    case (state)
      WAIT_ROLL: begin
        // First roll of a turn always frees every die.
        if (roll_edge) begin
          state_n      = ANIM;
          roll_count_n = 2'd1;
          hold_mask_n  = 5'b00000;
          roll_en_n    = 1'b1;
          gap_cnt_n    = '0;
          pulse_cnt_n  = 16'd1;
        end
      end
      ANIM: begin
        // roll_en high with the pulse count at target marks the final pulse cycle.
        if (roll_en && pulse_cnt == PULSES) begin
          state_n     = DECIDE;
          gap_cnt_n   = '0;
          pulse_cnt_n = '0;
        end else if (gap_cnt == GAP_LAST) begin
          roll_en_n   = 1'b1;
          gap_cnt_n   = '0;
          pulse_cnt_n = pulse_cnt + 16'd1;
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
        end
      end
      DECIDE: begin
        if (confirm_edge) begin
          score_commit_n = 1'b1;
          roll_count_n   = 2'd0;
          hold_mask_n    = 5'b00000;
          if (turn_num == LAST_TURN) begin
            state_n = GAME_OVER;
          end else begin
            turn_num_n = turn_num + 4'd1;
            state_n    = WAIT_ROLL;
          end
        end else if (roll_edge && roll_count < MAX_R) begin
          state_n      = ANIM;
          roll_count_n = roll_count + 2'd1;
          hold_mask_n  = hold_sw;
          roll_en_n    = 1'b1;
          gap_cnt_n    = '0;
          pulse_cnt_n  = 16'd1;
        end
      end
      GAME_OVER: begin
        if (confirm_edge) begin
          turn_num_n   = 4'd1;
          roll_count_n = 2'd0;
          state_n      = WAIT_ROLL;
        end
      end
      default: state_n = WAIT_ROLL;
    endcase

    can_select_n = (state_n == DECIDE);
    game_over_n  = (state_n == GAME_OVER);
  end

endmodule

// File: tb/tb_yacht_turn_controller.sv
// tb/tb_yacht_turn_controller.sv - scoreboard bench for yacht_turn_controller
module tb_yacht_turn_controller;

  localparam int P    = 8;
  localparam int G    = 4;
  localparam int MAXR = 3;
  localparam int NT   = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_roll, btn_confirm;
  logic [4:0] hold_sw;
  logic       roll_en, can_select, score_commit, game_over;
  logic [4:0] hold_mask;
  logic [1:0] roll_count;
  logic [3:0] turn_num;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_roll_q[$];
  int exp_commit_q[$];

  yacht_turn_controller #(
    .ANIM_PULSES(P), .ANIM_GAP(G), .MAX_ROLLS(MAXR), .NUM_TURNS(NT)
  ) dut (
    .clk(clk), .reset(reset), .btn_roll(btn_roll), .btn_confirm(btn_confirm),
    .hold_sw(hold_sw), .roll_en(roll_en), .hold_mask(hold_mask),
    .roll_count(roll_count), .turn_num(turn_num), .can_select(can_select),
    .score_commit(score_commit), .game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side: every observed strobe must match the oldest expected cycle.
  always @(negedge clk) begin
    if (roll_en === 1'b1) begin
      if (exp_roll_q.size() == 0) check("roll_en_unexpected", 1, 0);
      else check("roll_en_cycle", cyc, exp_roll_q.pop_front());
    end
    if (score_commit === 1'b1) begin
      if (exp_commit_q.size() == 0) check("commit_unexpected", 1, 0);
      else check("commit_cycle", cyc, exp_commit_q.pop_front());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press roll; when an animation is expected, wait through it and check can_select timing.
  task automatic do_roll(input string tag, input bit anim, input int exp_cnt, input logic [4:0] exp_mask);
    int c;
    c = cyc;
    btn_roll = 1'b1;
    if (anim) for (int k = 0; k < P; k++) exp_roll_q.push_back(c + 1 + k * G);
    tick();
    btn_roll = 1'b0;
    check({tag, "_count"}, roll_count, exp_cnt);
    check({tag, "_mask"}, hold_mask, exp_mask);
    if (anim) begin
      check({tag, "_sel_lo"}, can_select, 0);
      tick((P - 1) * G);
      check({tag, "_sel_pre"}, can_select, 0);
      tick();
      check({tag, "_sel_hi"}, can_select, 1);
    end else begin
      tick(2 * G);
      check({tag, "_sel_hold"}, can_select, 1);
    end
    tick();
  endtask

  task automatic do_confirm(input string tag, input bit commit, input int exp_turn, input int exp_over);
    btn_confirm = 1'b1;
    if (commit) exp_commit_q.push_back(cyc + 1);
    tick();
    btn_confirm = 1'b0;
    check({tag, "_turn"}, turn_num, exp_turn);
    check({tag, "_count"}, roll_count, 0);
    check({tag, "_sel"}, can_select, 0);
    check({tag, "_over"}, game_over, exp_over);
    tick(2);
  endtask

  initial begin
    reset = 1'b1; btn_roll = 1'b1; btn_confirm = 1'b0; hold_sw = 5'b11111;
    tick(3);
    reset = 1'b0;
    tick(4);
    check("rst_count", roll_count, 0);
    check("rst_turn", turn_num, 1);
    check("rst_mask", hold_mask, 0);
    check("rst_sel", can_select, 0);
    check("rst_over", game_over, 0);
    btn_roll = 1'b0;
    tick();

    do_roll("roll1", 1'b1, 1, 5'b00000);

    hold_sw = 5'b10101;
    begin
      int c;
      c = cyc;
      btn_roll = 1'b1;
      for (int k = 0; k < P; k++) exp_roll_q.push_back(c + 1 + k * G);
      tick();
      btn_roll = 1'b0;
      check("roll2_mask", hold_mask, 5'b10101);
      hold_sw = 5'b01010;
      tick(P * G);
      check("roll2_mask_frozen", hold_mask, 5'b10101);
      check("roll2_count", roll_count, 2);
      check("roll2_sel", can_select, 1);
      tick();
    end

    do_roll("roll3", 1'b1, 3, 5'b01010);
    do_roll("roll_limit", 1'b0, 3, 5'b01010);

    // Confirm and roll together: confirm wins, no animation.
    btn_roll = 1'b1;
    do_confirm("both", 1'b1, 2, 0);
    btn_roll = 1'b0;
    tick();

    hold_sw = 5'b11111;
    for (int t = 2; t <= NT; t++) begin
      do_roll("turn_roll", 1'b1, 1, 5'b00000);
      do_confirm("turn_commit", 1'b1, (t == NT) ? NT : t + 1, (t == NT) ? 1 : 0);
    end

    btn_roll = 1'b1;
    tick(3);
    btn_roll = 1'b0;
    tick(G * 2);
    check("go_roll_ignored_count", roll_count, 0);
    check("go_still_over", game_over, 1);
    do_confirm("new_game", 1'b0, 1, 0);

    // Reset asserted during the third pulse of an animation.
    begin
      int c;
      c = cyc;
      btn_roll = 1'b1;
      for (int k = 0; k < P; k++) exp_roll_q.push_back(c + 1 + k * G);
      tick();
      btn_roll = 1'b0;
      while (cyc < c + 1 + 2 * G) tick();
      @(negedge clk);
      #1;
      reset = 1'b1;
      exp_roll_q.delete();
      tick();
      reset = 1'b0;
      check("midrst_roll_en", roll_en, 0);
      check("midrst_count", roll_count, 0);
      check("midrst_mask", hold_mask, 0);
      check("midrst_turn", turn_num, 1);
      check("midrst_sel", can_select, 0);
      check("midrst_commit", score_commit, 0);
      check("midrst_over", game_over, 0);
      tick(P * G + 8);
    end

    check("roll_queue_drained", exp_roll_q.size(), 0);
    check("commit_queue_drained", exp_commit_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/yacht_turn_controller.md
# yacht_turn_controller

Turn sequencer for the Yacht Dice game. It sits between the debounced front-panel buttons and switches and the dice manager. It converts a roll button press into a timed burst of single-cycle `roll_en` pulses, which give a visible "tumbling" animation. It also limits each turn to `MAX_ROLLS` rolls, forces all dice free on the first roll of a turn, and counts turns through score commit to game over.

## Interface
Parameters:
- `ANIM_PULSES`, default 8: number of `roll_en` pulses per roll (≥1).
- `ANIM_GAP`, default 4: cycles between consecutive pulse starts (≥1).
- `MAX_ROLLS`, default 3: rolls allowed per turn (1..3).
- `NUM_TURNS`, default 12: turns per game (1..15).

Ports:
- `clk`, in, 1: system clock. One clock domain; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `btn_roll`, in, 1: roll button level, already debounced and synchronized.
- `btn_confirm`, in, 1: score-confirm button level, already debounced and synchronized.
- `hold_sw`, in, 5: DIP hold switches; bit i = 1 holds die i+1.
- `roll_en`, out, 1: one-cycle roll strobe to the dice manager.
- `hold_mask`, out, 5: hold vector to the dice manager.
- `roll_count`, out, 2: rolls taken in the current turn (0..MAX_ROLLS).
- `turn_num`, out, 4: current turn (1..NUM_TURNS).
- `can_select`, out, 1: high while a score category may be confirmed.
- `score_commit`, out, 1: one-cycle pulse when the turn's score is committed.
- `game_over`, out, 1: high after the final turn is committed.

## Operation
Edge detection:
- `roll_edge = btn_roll & ~roll_q` and `confirm_edge = btn_confirm & ~conf_q`, where `roll_q` and `conf_q` are registered copies of the buttons.
- `roll_q` and `conf_q` reset to 1, so a button held through reset does not produce an edge.
- Only edges act. Button levels are otherwise ignored.

States:
- `WAIT_ROLL`, with `roll_count` = 0:
  - `roll_edge` → `ANIM`; `roll_count` becomes 1; `hold_mask` is latched to `5'b00000`, because holds are illegal before the first roll.
  - `confirm_edge` is ignored.
- `ANIM`:
  - Issues `ANIM_PULSES` pulses on `roll_en`, spaced `ANIM_GAP` cycles apart, using a gap counter and a pulse counter.
  - Both buttons are ignored.
  - `hold_mask` stays frozen for the whole animation.
  - The cycle after the last pulse → `DECIDE`.
- `DECIDE`, with `can_select` = 1:
  - `confirm_edge` → `score_commit` = 1 for one cycle, `roll_count` ← 0, `hold_mask` ← 0.
    - If `turn_num` = `NUM_TURNS`: → `GAME_OVER`, and `turn_num` holds.
    - Otherwise: `turn_num` ← `turn_num` + 1, → `WAIT_ROLL`.
  - `roll_edge` with `roll_count` < `MAX_ROLLS` → `ANIM`; `roll_count` + 1; `hold_mask` ← `hold_sw` sampled on the edge cycle.
  - `roll_edge` with `roll_count` = `MAX_ROLLS` is ignored.
  - If both edges occur in the same cycle, confirm wins and the roll is dropped.
- `GAME_OVER`, with `game_over` = 1:
  - `roll_edge` is ignored.
  - `confirm_edge` starts a new game: `turn_num` ← 1, `roll_count` ← 0, `game_over` ← 0, → `WAIT_ROLL`. No `score_commit` pulse is issued.

Other rules:
- `can_select` = 1 only in `DECIDE`.
- `roll_en` is never asserted outside `ANIM`.
- All outputs are registered.

## Timing
- Reset values:
  - state `WAIT_ROLL`
  - `roll_en` = 0, `score_commit` = 0, `can_select` = 0, `game_over` = 0
  - `hold_mask` = 0, `roll_count` = 0, `turn_num` = 1
  - gap and pulse counters = 0
- Asserting `reset` in any state, including mid-`ANIM`, returns to these values at the next edge. No further `roll_en` is issued.
- Roll timing, for a `roll_edge` sampled in cycle T:
  - `roll_count`, `hold_mask` and state `ANIM` are visible from T+1.
  - `roll_en` is high in cycles T+1+k·`ANIM_GAP` for k = 0..`ANIM_PULSES`−1.
  - `can_select` rises at T+2+(`ANIM_PULSES`−1)·`ANIM_GAP`. With the defaults: pulses at T+1, T+5, …, T+29; `can_select` at T+30.
  - With `ANIM_GAP` = 1, the pulses occupy consecutive cycles.
- Commit timing, for a `confirm_edge` sampled in cycle T:
  - `score_commit` is high in T+1 only.
  - `turn_num`, `roll_count`, `can_select` = 0 and the new state all take effect in T+1.
  - `game_over` rises in T+1 on the final turn.
- A new `roll_edge` requires `btn_roll` to be low for at least one sampled cycle.

## Test plan
- Hold-through-reset: `btn_roll` = 1 across reset release → no `roll_en` and `roll_count` = 0. After one low cycle, a press → 8 `roll_en` pulses 4 cycles apart, `roll_count` = 1, `hold_mask` = 00000 even with `hold_sw` = 11111.
- Second roll: in `DECIDE` with `hold_sw` = 10101, press roll → `hold_mask` = 10101 from T+1; a `hold_sw` change during `ANIM` does not alter the mask; `roll_count` = 2.
- Roll limit: after the third roll, press roll → no `roll_en`, `roll_count` stays 3, `can_select` stays 1.
- Simultaneous press: `roll_edge` and `confirm_edge` in the same `DECIDE` cycle → `score_commit` pulse, no `roll_en`, `turn_num` + 1, `roll_count` = 0.
- Full game: 12 commits → `game_over` = 1 and `turn_num` = 12 after the 12th; rolls ignored; then confirm → `turn_num` = 1, `game_over` = 0, no `score_commit`.
- Mid-animation reset: assert `reset` at the 3rd `roll_en` → all outputs at reset values next cycle and no further pulses.
